cascade_slave_responder: RTL and testbench
==========================================

Name: cascade_slave_responder

Overview:
- Slave-side end of the 8259A cascade protocol.
- The master drives the ID of the requesting slave onto CASBus during the first INTA pulse. This block captures CASBus and compares it with its own slave ID.
- On a match, the block reports the acknowledged level to the priority/ISR logic and drives the interrupt vector onto the data bus during the second INTA pulse.
- It sits between the cascade pins, the ICW2/ICW3 registers and the priority resolver of a PIC configured as slave.

Parameters:
- GAP_TIMEOUT, 64, max clk cycles allowed in GAP (between INTA pulses) before abort.
- TO_W, 7, width of the timeout counter; must hold GAP_TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- INTA_n  in  1  CPU acknowledge strobe, active low, asynchronous to clk.
- SPEN  in  1  0 = slave mode (block active), 1 = master mode (block idle).
- CASBus  in  3  cascade lines from the master.
- slaveID  in  3  ICW3[2:0] of this slave.
- vectorBase  in  5  ICW2[7:3].
- AEOI  in  1  automatic-EOI mode from ICW4.
- intPending  in  1  resolver has an unmasked pending request.
- interruptLocation  in  3  highest-priority pending level from the resolver.
- selected  out  1  this slave was addressed in the current INTA sequence.
- isrSet  out  1  one-cycle pulse: set ISR / clear IRR for ackLevel.
- ackLevel  out  3  locked level for the current sequence.
- dataOut  out  8  vector byte.
- dataOE  out  1  data bus output enable.
- eoiPulse  out  1  one-cycle automatic EOI for ackLevel.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - Both synchronizer flops = 1.
  - selected, isrSet, ackLevel, dataOut, dataOE, eoiPulse, timeout counter all = 0.
  - Reset asserted mid-sequence drops dataOE immediately.
- Synchronizer: INTA_n passes through 2 flops (s1, s2), plus a registered s3.
  - fall = s3 & ~s2; rise = ~s3 & s2.
  - Pin-to-edge detect latency is 3 clk cycles.
- State machine: IDLE, ACK1, GAP, ACK2.
- IDLE:
  - fall with SPEN=0 -> ACK1.
  - In the same cycle, register selected = (CASBus == slaveID).
  - If selected and intPending=1: ackLevel = interruptLocation; pulse isrSet in the next cycle.
  - If selected and intPending=0 (spurious): ackLevel = 7; no isrSet.
  - fall with SPEN=1: stay in IDLE; all outputs stay 0.
- ACK1:
  - ackLevel and selected are frozen; later changes on interruptLocation or CASBus are ignored.
  - rise -> GAP; timeout counter cleared.
- GAP:
  - Counter increments each cycle.
  - fall -> ACK2. If selected: dataOE=1 and dataOut={vectorBase, ackLevel}, registered, visible the cycle after fall.
  - Counter reaches GAP_TIMEOUT -> IDLE; selected cleared; no vector, no eoiPulse.
- ACK2:
  - dataOE and dataOut are held.
  - rise -> IDLE. dataOE=0 and dataOut=0 in the next cycle.
  - If selected and AEOI=1 and the sequence was not spurious: pulse eoiPulse for one cycle.
  - selected clears on entry to IDLE.
- SPEN=1 in any non-IDLE state: abort to IDLE next cycle; dataOE=0; no eoiPulse.
- Unselected slave: follows the same state sequence (stays in step with the bus) but never asserts isrSet, dataOE or eoiPulse.
- isrSet and eoiPulse are exactly one cycle wide and are never asserted in the same cycle.
- A fall in ACK1 or ACK2, or a rise in IDLE or GAP, cannot occur after synchronization; such cases are ignored.

Test Plan:
- Selected sequence:
  - Stimulus: slaveID=3, CASBus=3, SPEN=0, intPending=1, interruptLocation=5, vectorBase=5'b01000; two INTA_n low pulses of 10 cycles with a 10-cycle gap.
  - Required: isrSet pulse with ackLevel=5; dataOE=1 with dataOut=8'h45 during the second pulse; dataOE=0 after it; no eoiPulse.
- Not addressed:
  - Stimulus: as the selected sequence but CASBus=2.
  - Required: selected=0, no isrSet, dataOE never 1, state returns to IDLE after the second pulse.
- AEOI and level freeze:
  - Stimulus: AEOI=1, selected sequence, with interruptLocation changed 5->1 during the gap.
  - Required: dataOut=8'h45; exactly one eoiPulse, with ackLevel=5, the cycle after the second rise.
- Spurious:
  - Stimulus: selected with intPending=0.
  - Required: no isrSet; dataOut={vectorBase,3'b111}=8'h47; no eoiPulse even with AEOI=1.
- Gap timeout:
  - Stimulus: only one INTA pulse, then idle for 70 cycles.
  - Required: return to IDLE at GAP_TIMEOUT (64); a later single fall starts a fresh ACK1 with a fresh CAS compare.
- Abort:
  - Stimulus: SPEN set to 1 during ACK2, or rst_n=0 during ACK2.
  - Required: dataOE drops (next cycle for SPEN, immediately for reset); all outputs 0; no eoiPulse.

Source files
------------

// File: rtl/cascade_slave_responder.sv
// Slave-side responder for the 8259A cascade protocol.
//
// On the first INTA pulse it captures CASBus and compares it with this
// slave's ID. On a match it locks the acknowledged level and pulses isrSet.
// During the second INTA pulse it drives {vectorBase, ackLevel} onto the
// data bus. With AEOI set it also issues an automatic EOI.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   INTA_n            CPU acknowledge strobe (async, active low)
//   SPEN              0 = slave mode (active), 1 = master mode (idle)
//   CASBus            cascade ID driven by the master
//   slaveID           ICW3[2:0] of this slave
//   vectorBase        ICW2[7:3]
//   AEOI              automatic-EOI mode from ICW4
//   intPending        resolver has an unmasked pending request
//   interruptLocation highest-priority pending level
//   selected          this slave was addressed in the current sequence
//   isrSet            one-cycle pulse: set ISR / clear IRR for ackLevel
//   ackLevel          level locked for the current sequence
//   dataOut, dataOE   vector byte and its output enable
//   eoiPulse          one-cycle automatic EOI for ackLevel
module cascade_slave_responder #(
  parameter int unsigned GAP_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTA_n,
  input  logic       SPEN,
  input  logic [2:0] CASBus,
  input  logic [2:0] slaveID,
  input  logic [4:0] vectorBase,
  input  logic       AEOI,
  input  logic       intPending,
  input  logic [2:0] interruptLocation,
  output logic       selected,
  output logic       isrSet,
  output logic [2:0] ackLevel,
  output logic [7:0] dataOut,
  output logic       dataOE,
  output logic       eoiPulse
);

  typedef enum logic [1:0] {StIdle, StAck1, StGap, StAck2} state_e;

  state_e          state_q, state_d;
  logic            s1_q, s2_q, s3_q;
  logic            fall, rise;
  logic            sel_q, sel_d;
  logic [2:0]      lvl_q, lvl_d;
  logic            spur_q, spur_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            oe_q, oe_d;
  logic [7:0]      data_q, data_d;
  logic            isr_q, isr_d;
  logic            eoi_q, eoi_d;

  // INTA_n is asynchronous: two synchronizer flops plus one history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= INTA_n;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall = s3_q & ~s2_q;
  assign rise = ~s3_q & s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      lvl_q   <= 3'd0;
      spur_q  <= 1'b0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      data_q  <= 8'd0;
      isr_q   <= 1'b0;
      eoi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lvl_q   <= lvl_d;
      spur_q  <= spur_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      isr_q   <= isr_d;
      eoi_q   <= eoi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lvl_d   = lvl_q;
    spur_d  = spur_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    data_d  = data_q;
    isr_d   = 1'b0;
    eoi_d   = 1'b0;

    if (state_q != StIdle && SPEN) begin
      // Switched to master mode mid-sequence: drop everything quietly.
      state_d = StIdle;
      sel_d   = 1'b0;
      lvl_d   = 3'd0;
      spur_d  = 1'b0;
      cnt_d   = '0;
      oe_d    = 1'b0;
      data_d  = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (fall && !SPEN) begin
            state_d = StAck1;
            sel_d   = (CASBus == slaveID);
            if (CASBus == slaveID) begin
              if (intPending) begin
                lvl_d  = interruptLocation;
                spur_d = 1'b0;
                isr_d  = 1'b1;
              end else begin
                // Request vanished before the acknowledge: spurious level 7.
                lvl_d  = 3'd7;
                spur_d = 1'b1;
              end
            end else begin
              lvl_d  = 3'd0;
              spur_d = 1'b0;
            end
          end
        end
        StAck1: begin
          if (rise) begin
            state_d = StGap;
            cnt_d   = '0;
          end
        end
        StGap: begin
          if (fall) begin
            state_d = StAck2;
            if (sel_q) begin
              oe_d   = 1'b1;
              data_d = {vectorBase, lvl_q};
            end
          end else if (cnt_q == TO_W'(GAP_TIMEOUT - 1)) begin
            // Second INTA never came: abandon the sequence.
            state_d = StIdle;
            sel_d   = 1'b0;
            lvl_d   = 3'd0;
            spur_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        StAck2: begin
          if (rise) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            data_d  = 8'd0;
            sel_d   = 1'b0;
            eoi_d   = sel_q & AEOI & ~spur_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign selected = sel_q;
  assign isrSet   = isr_q;
  assign ackLevel = lvl_q;
  assign dataOut  = data_q;
  assign dataOE   = oe_q;
  assign eoiPulse = eoi_q;

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Directed self-checking bench for cascade_slave_responder.
module tb_cascade_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       INTA_n;
  logic       SPEN;
  logic [2:0] CASBus;
  logic [2:0] slaveID;
  logic [4:0] vectorBase;
  logic       AEOI;
  logic       intPending;
  logic [2:0] interruptLocation;
  logic       selected;
  logic       isrSet;
  logic [2:0] ackLevel;
  logic [7:0] dataOut;
  logic       dataOE;
  logic       eoiPulse;

  int vectors = 0;
  int miscompares = 0;

  // Pulse/strobe observations, sampled on the falling edge.
  int         isr_cnt, eoi_cnt, oe_cnt, both_cnt;
  logic [2:0] isr_lvl, eoi_lvl;
  logic [7:0] oe_data;

  // Values captured by run_seq at fixed points of the sequence.
  logic       mid_sel;
  logic [2:0] mid_lvl;
  logic       ack2_oe;
  logic [7:0] ack2_data;
  logic       eoi_at3, eoi_at4;

  cascade_slave_responder #(.GAP_TIMEOUT(64), .TO_W(7)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .INTA_n           (INTA_n),
    .SPEN             (SPEN),
    .CASBus           (CASBus),
    .slaveID          (slaveID),
    .vectorBase       (vectorBase),
    .AEOI             (AEOI),
    .intPending       (intPending),
    .interruptLocation(interruptLocation),
    .selected         (selected),
    .isrSet           (isrSet),
    .ackLevel         (ackLevel),
    .dataOut          (dataOut),
    .dataOE           (dataOE),
    .eoiPulse         (eoiPulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (isrSet) begin isr_cnt++; isr_lvl = ackLevel; end
    if (eoiPulse) begin eoi_cnt++; eoi_lvl = ackLevel; end
    if (dataOE) begin oe_cnt++; oe_data = dataOut; end
    if (isrSet && eoiPulse) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    isr_cnt = 0; eoi_cnt = 0; oe_cnt = 0; both_cnt = 0;
    isr_lvl = 3'd0; eoi_lvl = 3'd0; oe_data = 8'd0;
  endtask

  // Full two-pulse INTA sequence: 10 low, 10 high, 10 low, then 6 idle.
  task automatic run_seq(input bit chg_loc);
    INTA_n = 1'b0;
    tick(5);
    mid_sel = selected;
    mid_lvl = ackLevel;
    tick(5);
    INTA_n = 1'b1;
    tick(4);
    if (chg_loc) interruptLocation = 3'd1;
    tick(6);
    INTA_n = 1'b0;
    tick(5);
    ack2_oe   = dataOE;
    ack2_data = dataOut;
    tick(5);
    INTA_n = 1'b1;
    tick(3);
    eoi_at3 = eoiPulse;
    tick(1);
    eoi_at4 = eoiPulse;
    tick(2);
  endtask

  task automatic set_defaults();
    SPEN = 1'b0; CASBus = 3'd3; slaveID = 3'd3; vectorBase = 5'b01000;
    AEOI = 1'b0; intPending = 1'b1; interruptLocation = 3'd5; INTA_n = 1'b1;
  endtask

  task automatic test_reset();
    set_defaults();
    rst_n = 1'b0;
    tick(2);
    vectors++;
    if ({selected, isrSet, ackLevel, dataOut, dataOE, eoiPulse} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got sel=%b isr=%b lvl=%0d data=%h oe=%b eoi=%b want all 0",
               selected, isrSet, ackLevel, dataOut, dataOE, eoiPulse);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_selected();
    set_defaults();
    clear_obs();
    run_seq(1'b0);
    vectors++;
    if (mid_sel !== 1'b1 || mid_lvl !== 3'd5) begin
      miscompares++;
      $display("FAIL sel_ack1 got sel=%b lvl=%0d want sel=1 lvl=5", mid_sel, mid_lvl);
    end
    vectors++;
    if (isr_cnt !== 1 || isr_lvl !== 3'd5) begin
      miscompares++;
      $display("FAIL sel_isrset got count=%0d lvl=%0d want count=1 lvl=5", isr_cnt, isr_lvl);
    end
    vectors++;
    if (ack2_oe !== 1'b1 || ack2_data !== 8'h45) begin
      miscompares++;
      $display("FAIL sel_vector got oe=%b data=%h want oe=1 data=45", ack2_oe, ack2_data);
    end
    vectors++;
    if (dataOE !== 1'b0 || dataOut !== 8'h00 || selected !== 1'b0 || eoi_cnt !== 0) begin
      miscompares++;
      $display("FAIL sel_end got oe=%b data=%h sel=%b eoi_count=%0d want 0,00,0,0",
               dataOE, dataOut, selected, eoi_cnt);
    end
  endtask

  task automatic test_not_addressed();
    set_defaults();
    CASBus = 3'd2;
    clear_obs();
    run_seq(1'b0);
    vectors++;
    if (mid_sel !== 1'b0 || mid_lvl !== 3'd0) begin
      miscompares++;
      $display("FAIL unsel_ack1 got sel=%b lvl=%0d want sel=0 lvl=0", mid_sel, mid_lvl);
    end
    vectors++;
    if (isr_cnt !== 0 || oe_cnt !== 0 || eoi_cnt !== 0) begin
      miscompares++;
      $display("FAIL unsel_quiet got isr=%0d oe=%0d eoi=%0d want 0,0,0",
               isr_cnt, oe_cnt, eoi_cnt);
    end
  endtask

  task automatic test_aeoi_freeze();
    set_defaults();
    AEOI = 1'b1;
    clear_obs();
    run_seq(1'b1);
    vectors++;
    if (ack2_data !== 8'h45 || ack2_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL aeoi_vector got oe=%b data=%h want oe=1 data=45", ack2_oe, ack2_data);
    end
    vectors++;
    if (eoi_cnt !== 1 || eoi_lvl !== 3'd5) begin
      miscompares++;
      $display("FAIL aeoi_pulse got count=%0d lvl=%0d want count=1 lvl=5", eoi_cnt, eoi_lvl);
    end
    vectors++;
    if (eoi_at3 !== 1'b1 || eoi_at4 !== 1'b0) begin
      miscompares++;
      $display("FAIL aeoi_timing got at3=%b at4=%b want 1,0", eoi_at3, eoi_at4);
    end
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL aeoi_overlap got %0d overlapping cycles want 0", both_cnt);
    end
  endtask

  task automatic test_spurious();
    set_defaults();
    AEOI = 1'b1;
    intPending = 1'b0;
    clear_obs();
    run_seq(1'b0);
    vectors++;
    if (isr_cnt !== 0 || mid_lvl !== 3'd7) begin
      miscompares++;
      $display("FAIL spur_ack got isr=%0d lvl=%0d want isr=0 lvl=7", isr_cnt, mid_lvl);
    end
    vectors++;
    if (ack2_data !== 8'h47 || eoi_cnt !== 0) begin
      miscompares++;
      $display("FAIL spur_vector got data=%h eoi=%0d want data=47 eoi=0", ack2_data, eoi_cnt);
    end
  endtask

  task automatic test_gap_timeout();
    set_defaults();
    clear_obs();
    INTA_n = 1'b0;
    tick(10);
    INTA_n = 1'b1;
    tick(50);
    vectors++;
    if (selected !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_wait got sel=%b want 1", selected);
    end
    tick(20);
    vectors++;
    if (selected !== 1'b0 || ackLevel !== 3'd0 || oe_cnt !== 0 || eoi_cnt !== 0) begin
      miscompares++;
      $display("FAIL gap_timeout got sel=%b lvl=%0d oe=%0d eoi=%0d want 0,0,0,0",
               selected, ackLevel, oe_cnt, eoi_cnt);
    end
    // Fresh sequence after the timeout: new compare, new locked level.
    clear_obs();
    interruptLocation = 3'd2;
    run_seq(1'b0);
    vectors++;
    if (mid_sel !== 1'b1 || isr_cnt !== 1 || isr_lvl !== 3'd2 || ack2_data !== 8'h42) begin
      miscompares++;
      $display("FAIL gap_fresh got sel=%b isr=%0d lvl=%0d data=%h want 1,1,2,42",
               mid_sel, isr_cnt, isr_lvl, ack2_data);
    end
  endtask

  task automatic test_master_mode();
    set_defaults();
    SPEN = 1'b1;
    clear_obs();
    run_seq(1'b0);
    vectors++;
    if (mid_sel !== 1'b0 || isr_cnt !== 0 || oe_cnt !== 0) begin
      miscompares++;
      $display("FAIL master_idle got sel=%b isr=%0d oe=%0d want 0,0,0", mid_sel, isr_cnt, oe_cnt);
    end
    SPEN = 1'b0;
    tick(2);
  endtask

  task automatic test_abort();
    // SPEN raised during ACK2.
    set_defaults();
    AEOI = 1'b1;
    clear_obs();
    INTA_n = 1'b0; tick(10); INTA_n = 1'b1; tick(10); INTA_n = 1'b0; tick(5);
    vectors++;
    if (dataOE !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre got oe=%b want 1", dataOE);
    end
    SPEN = 1'b1;
    tick(1);
    vectors++;
    if ({selected, isrSet, ackLevel, dataOut, dataOE, eoiPulse} !== 15'd0) begin
      miscompares++;
      $display("FAIL abort_spen got sel=%b lvl=%0d data=%h oe=%b eoi=%b want all 0",
               selected, ackLevel, dataOut, dataOE, eoiPulse);
    end
    INTA_n = 1'b1; tick(6); SPEN = 1'b0; tick(2);
    vectors++;
    if (eoi_cnt !== 0) begin
      miscompares++;
      $display("FAIL abort_spen_eoi got %0d want 0", eoi_cnt);
    end
    // Reset asserted during ACK2.
    clear_obs();
    INTA_n = 1'b0; tick(10); INTA_n = 1'b1; tick(10); INTA_n = 1'b0; tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({selected, isrSet, ackLevel, dataOut, dataOE, eoiPulse} !== 15'd0) begin
      miscompares++;
      $display("FAIL abort_reset got sel=%b lvl=%0d data=%h oe=%b eoi=%b want all 0",
               selected, ackLevel, dataOut, dataOE, eoiPulse);
    end
    INTA_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    vectors++;
    if (eoi_cnt !== 0 || dataOE !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset_after got eoi=%0d oe=%b want 0,0", eoi_cnt, dataOE);
    end
  endtask

  task automatic test_back_to_back();
    set_defaults();
    clear_obs();
    run_seq(1'b0);
    interruptLocation = 3'd6;
    run_seq(1'b0);
    vectors++;
    if (isr_cnt !== 2 || isr_lvl !== 3'd6 || ack2_data !== 8'h46) begin
      miscompares++;
      $display("FAIL b2b got isr=%0d lvl=%0d data=%h want 2,6,46", isr_cnt, isr_lvl, ack2_data);
    end
  endtask

  initial begin
    test_reset();
    test_selected();
    test_not_addressed();
    test_aeoi_freeze();
    test_spurious();
    test_gap_timeout();
    test_master_mode();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
